// File: rtl/uart_link_tester.sv
// rtl/uart_link_tester.sv - UART TX/RX pair with loopback word checker and error counter
module uart_link_tester #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 st,
   input  logic [DATA_BITS-1:0] dat,
   output logic                 txd,
   output logic                 busy,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_dat,
   output logic                 rx_ok,
   output logic                 par_err,
   output logic                 frm_err,
   output logic                 match,
   output logic [7:0]           err_cnt
);

   localparam int DIV  = CLK_HZ / BAUD;
   localparam int CW   = $clog2(DIV + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF  = CW'(DIV / 2 - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic          PAR_ODD   = (PARITY == 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   // ---------------- transmitter ----------------
   state_t                 tx_state, tx_next;
   logic                   st_s1, st_s2, st_s3, st_rise;
   logic [CW-1:0]          tx_cnt;
   logic [3:0]             tx_idx;
   logic [DATA_BITS-1:0]   tx_sh;
   logic [DATA_BITS-1:0]   last_tx;
   logic                   tx_par;
   logic                   tx_load;
   logic                   tx_bit_end;

   assign tx_bit_end = (tx_cnt == CNT_LAST);
   assign busy       = (tx_state != S_IDLE);

   // Synchronise st and register its rising edge; the extra stage sets the start latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_s1   <= 1'b0;
         st_s2   <= 1'b0;
         st_s3   <= 1'b0;
         st_rise <= 1'b0;
      end else begin
         st_s1   <= st;
         st_s2   <= st_s1;
         st_s3   <= st_s2;
         st_rise <= st_s2 & ~st_s3;
      end
   end

   // TX state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_state <= S_IDLE;
      else        tx_state <= tx_next;
   end

   // TX next state; a start edge seen while busy is simply dropped.
   always_comb begin
      tx_next = tx_state;
      tx_load = 1'b0;
      case (tx_state)
         S_IDLE:  if (st_rise) begin
                     tx_next = S_START;
                     tx_load = 1'b1;
                  end
         S_START: if (tx_bit_end) tx_next = S_DATA;
         S_DATA:  if (tx_bit_end && tx_idx == DATA_LAST)
                     tx_next = (PARITY != 0) ? S_PAR : S_STOP;
         S_PAR:   if (tx_bit_end) tx_next = S_STOP;
         S_STOP:  if (tx_bit_end && tx_idx == STOP_LAST) tx_next = S_IDLE;
         default: tx_next = S_IDLE;
      endcase
   end

   // TX bit timer, bit index and data shifter; the word and its parity are frozen at start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_cnt  <= '0;
         tx_idx  <= '0;
         tx_sh   <= '0;
         last_tx <= '0;
         tx_par  <= 1'b0;
      end else if (tx_load) begin
         tx_sh   <= dat;
         last_tx <= dat;
         tx_par  <= (^dat) ^ PAR_ODD;
         tx_cnt  <= '0;
         tx_idx  <= '0;
      end else if (tx_state == S_IDLE) begin
         tx_cnt <= '0;
         tx_idx <= '0;
      end else if (tx_bit_end) begin
         tx_cnt <= '0;
         tx_idx <= (tx_next != tx_state) ? 4'd0 : tx_idx + 4'd1;
         if (tx_state == S_DATA) tx_sh <= tx_sh >> 1;
      end else begin
         tx_cnt <= tx_cnt + 1'b1;
      end
   end

   // Line level chosen by the current TX state; idle and stop bits are high.
   always_comb begin
      txd = 1'b1;
      case (tx_state)
         S_START: txd = 1'b0;
         S_DATA:  txd = tx_sh[0];
         S_PAR:   txd = tx_par;
         default: txd = 1'b1;
      endcase
   end

   // ---------------- receiver ----------------
   state_t                 rx_state, rx_next;
   logic                   rx_s1, rx_s2, rx_s3;
   logic                   rx_fall;
   logic [CW-1:0]          rx_cnt;
   logic [3:0]             rx_idx;
   logic [DATA_BITS-1:0]   rx_sh;
   logic                   rx_pbit;
   logic                   stop_bad;
   logic                   rx_sample;
   logic                   rx_done;

   assign rx_fall = rx_s3 & ~rx_s2;

   // Synchronise rxd; stages reset high so a reset never fakes a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_s3 <= 1'b1;
      end else begin
         rx_s1 <= rxd;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
      end
   end

   // RX state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_state <= S_IDLE;
      else        rx_state <= rx_next;
   end

   // RX next state: half-bit start check, then one sample per bit centre.
   always_comb begin
      rx_next   = rx_state;
      rx_done   = 1'b0;
      rx_sample = 1'b0;
      case (rx_state)
         S_IDLE:  if (rx_fall) rx_next = S_START;
         S_START: begin
                     rx_sample = (rx_cnt == CNT_HALF);
                     if (rx_sample) rx_next = rx_s2 ? S_IDLE : S_DATA;
                  end
         S_DATA:  begin
                     rx_sample = (rx_cnt == CNT_LAST);
                     if (rx_sample && rx_idx == DATA_LAST)
                        rx_next = (PARITY != 0) ? S_PAR : S_STOP;
                  end
         S_PAR:   begin
                     rx_sample = (rx_cnt == CNT_LAST);
                     if (rx_sample) rx_next = S_STOP;
                  end
         S_STOP:  begin
                     rx_sample = (rx_cnt == CNT_LAST);
                     if (rx_sample && rx_idx == STOP_LAST) begin
                        rx_next = S_IDLE;
                        rx_done = 1'b1;
                     end
                  end
         default: rx_next = S_IDLE;
      endcase
   end

   // RX timer, bit capture and frame delivery with parity/framing flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_sh    <= '0;
         rx_pbit  <= 1'b0;
         stop_bad <= 1'b0;
         rx_dat   <= '0;
         rx_ok    <= 1'b0;
         par_err  <= 1'b0;
         frm_err  <= 1'b0;
      end else begin
         rx_ok <= 1'b0;
         if (rx_state == S_IDLE || rx_sample) rx_cnt <= '0;
         else                                 rx_cnt <= rx_cnt + 1'b1;
         if (rx_state != rx_next) rx_idx <= '0;
         else if (rx_sample)      rx_idx <= rx_idx + 4'd1;
         if (rx_state == S_IDLE) stop_bad <= 1'b0;
         if (rx_sample && rx_state == S_DATA) rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
         if (rx_sample && rx_state == S_PAR)  rx_pbit <= rx_s2;
         if (rx_sample && rx_state == S_STOP && !rx_s2) stop_bad <= 1'b1;
         if (rx_done) begin
            rx_dat  <= rx_sh;
            rx_ok   <= 1'b1;
            par_err <= (PARITY != 0) && (rx_pbit != ((^rx_sh) ^ PAR_ODD));
            frm_err <= stop_bad | ~rx_s2;
         end
      end
   end

   // ---------------- checker ----------------
   // One clock after delivery, compare with the last sent word and count failures.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match   <= 1'b0;
         err_cnt <= 8'd0;
      end else if (rx_ok) begin
         match <= (rx_dat == last_tx) && !par_err && !frm_err;
         if (!((rx_dat == last_tx) && !par_err && !frm_err) && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule
